// File: rtl/delay_capture_monitor.sv
// delay_capture_monitor
// Measures how many cycles a DUT output takes to settle to an expected value
// after each stimulus pulse. Each result {status, latency, value} is queued
// in a small FIFO that a logger or host drains.
module delay_capture_monitor #(
  parameter int unsigned DATA_W     = 1,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned TIMEOUT    = 1000,
  parameter int unsigned STABLE     = 2,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stim_valid,
  input  logic [DATA_W-1:0] expect_data,
  input  logic [DATA_W-1:0] obs_data,
  input  logic              clear,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [CNT_W-1:0]  res_latency,
  output logic [1:0]        res_status,
  output logic [DATA_W-1:0] res_value,
  output logic              busy,
  output logic              overflow
);

  localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned ENTRY_W = 2 + CNT_W + DATA_W;

  localparam logic [CNT_W-1:0] TO_VAL     = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] STABLE_VAL = CNT_W'(STABLE);
  localparam logic [PTR_W-1:0] PTR_LAST   = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [PTR_W:0]   FULL_CNT   = (PTR_W + 1)'(FIFO_DEPTH);

  localparam logic [1:0] ST_SETTLED = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORTED = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_SETTLE
  } state_t;

  // Measurement state
  state_t             r_state;
  state_t             w_next_state;
  logic [DATA_W-1:0]  r_exp;
  logic [DATA_W-1:0]  w_exp_next;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cnt_next;
  logic [CNT_W-1:0]   r_first;
  logic [CNT_W-1:0]   w_first_next;
  logic [CNT_W-1:0]   r_run;
  logic [CNT_W-1:0]   w_run_next;

  logic [CNT_W-1:0]   w_cnt_inc;
  logic [CNT_W-1:0]   w_cnt_sat;
  logic [CNT_W-1:0]   w_run_inc;
  logic               w_match;
  logic               w_timeout_hit;

  // Result handed to the FIFO
  logic               w_push;
  logic [1:0]         w_push_status;
  logic [CNT_W-1:0]   w_push_latency;
  logic [ENTRY_W-1:0] w_push_entry;

  // FIFO storage
  logic [ENTRY_W-1:0] r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [PTR_W:0]     r_count;
  logic               r_overflow;
  logic               w_full;
  logic               w_pop;
  logic               w_wr_en;

  assign w_cnt_inc     = r_cnt + CNT_W'(1);
  assign w_cnt_sat     = (r_cnt >= TO_VAL) ? r_cnt : w_cnt_inc;
  assign w_run_inc     = r_run + CNT_W'(1);
  assign w_match       = (obs_data == r_exp);
  assign w_timeout_hit = (w_cnt_inc == TO_VAL);
  assign w_push_entry  = {w_push_status, w_push_latency, obs_data};

  // FSM state and measurement registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_exp   <= '0;
      r_cnt   <= '0;
      r_first <= '0;
      r_run   <= '0;
    end else begin
      r_state <= w_next_state;
      r_exp   <= w_exp_next;
      r_cnt   <= w_cnt_next;
      r_first <= w_first_next;
      r_run   <= w_run_next;
    end
  end

  // Next-state, counters and result generation; clear beats abort beats settle/timeout
  always_comb begin
    w_next_state   = r_state;
    w_exp_next     = r_exp;
    w_cnt_next     = r_cnt;
    w_first_next   = r_first;
    w_run_next     = r_run;
    w_push         = 1'b0;
    w_push_status  = ST_SETTLED;
    w_push_latency = '0;

    if (clear) begin
      w_next_state = S_IDLE;
      w_cnt_next   = '0;
      w_run_next   = '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (stim_valid) begin
            w_exp_next   = expect_data;
            w_cnt_next   = '0;
            w_next_state = S_WAIT;
          end
        end

        S_WAIT, S_SETTLE: begin
          w_cnt_next = w_cnt_sat;
          if (stim_valid) begin
            w_push         = 1'b1;
            w_push_status  = ST_ABORTED;
            w_push_latency = w_cnt_inc;
            w_exp_next     = expect_data;
            w_cnt_next     = '0;
            w_run_next     = '0;
            w_next_state   = S_WAIT;
          end else if (r_state == S_WAIT) begin
            if (w_match) begin
              w_first_next = w_cnt_inc;
              w_run_next   = CNT_W'(1);
              if (STABLE <= 1) begin
                w_push         = 1'b1;
                w_push_status  = ST_SETTLED;
                w_push_latency = w_cnt_inc;
                w_next_state   = S_IDLE;
              end else if (w_timeout_hit) begin
                w_push         = 1'b1;
                w_push_status  = ST_TIMEOUT;
                w_push_latency = TO_VAL;
                w_next_state   = S_IDLE;
              end else begin
                w_next_state = S_SETTLE;
              end
            end else if (w_timeout_hit) begin
              w_push         = 1'b1;
              w_push_status  = ST_TIMEOUT;
              w_push_latency = TO_VAL;
              w_next_state   = S_IDLE;
            end
          end else begin
            if (w_match) begin
              w_run_next = w_run_inc;
              if (w_run_inc == STABLE_VAL) begin
                w_push         = 1'b1;
                w_push_status  = ST_SETTLED;
                w_push_latency = r_first;
                w_next_state   = S_IDLE;
              end else if (w_timeout_hit) begin
                w_push         = 1'b1;
                w_push_status  = ST_TIMEOUT;
                w_push_latency = TO_VAL;
                w_next_state   = S_IDLE;
              end
            end else if (w_timeout_hit) begin
              w_push         = 1'b1;
              w_push_status  = ST_TIMEOUT;
              w_push_latency = TO_VAL;
              w_next_state   = S_IDLE;
            end else begin
              // Glitch: the run broke before reaching STABLE, keep waiting
              w_run_next   = '0;
              w_next_state = S_WAIT;
            end
          end
        end

        default: begin
          w_next_state = S_IDLE;
        end
      endcase
    end
  end

  assign w_full    = (r_count == FULL_CNT);
  assign res_valid = (r_count != '0);
  assign w_pop     = res_valid && res_ready;
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push
  assign w_wr_en   = w_push && (!w_full || w_pop);

  // Result FIFO: storage, pointers, occupancy and sticky overflow
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr_en) begin
        r_mem[r_wr_ptr] <= w_push_entry;
        r_wr_ptr        <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      if (w_wr_en && !w_pop) begin
        r_count <= r_count + (PTR_W + 1)'(1);
      end else if (!w_wr_en && w_pop) begin
        r_count <= r_count - (PTR_W + 1)'(1);
      end
      if (w_push && !w_wr_en) begin
        r_overflow <= 1'b1;
      end
    end
  end

  assign {res_status, res_latency, res_value} = r_mem[r_rd_ptr];
  assign busy     = (r_state != S_IDLE);
  assign overflow = r_overflow;

endmodule

// File: tb/tb_delay_capture_monitor.sv
// Scoreboard bench for delay_capture_monitor: expected entries are queued as
// stimulus is driven and compared when the FIFO head is popped.
module tb_delay_capture_monitor;

  localparam int unsigned DATA_W = 1;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TMO    = 20;
  localparam int unsigned STB    = 2;
  localparam int unsigned DEPTH  = 8;

  logic              clk;
  logic              rst_n;
  logic              stim_valid;
  logic [DATA_W-1:0] expect_data;
  logic [DATA_W-1:0] obs_data;
  logic              clear;
  logic              res_valid;
  logic              res_ready;
  logic [CNT_W-1:0]  res_latency;
  logic [1:0]        res_status;
  logic [DATA_W-1:0] res_value;
  logic              busy;
  logic              overflow;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [31:0] sb_q[$];

  delay_capture_monitor #(
    .DATA_W    (DATA_W),
    .CNT_W     (CNT_W),
    .TIMEOUT   (TMO),
    .STABLE    (STB),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .stim_valid (stim_valid),
    .expect_data(expect_data),
    .obs_data   (obs_data),
    .clear      (clear),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_latency(res_latency),
    .res_status (res_status),
    .res_value  (res_value),
    .busy       (busy),
    .overflow   (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ent(input logic [1:0] st, input int unsigned lat, input logic v);
    return {13'b0, st, 16'(lat), v};
  endfunction

  // Compare the head against the scoreboard whenever it is about to be popped
  always @(negedge clk) begin
    if (rst_n && res_valid && res_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_extra", {13'b0, res_status, res_latency, res_value}, 32'hDEAD_BEEF);
      end else begin
        check("sb_entry", {13'b0, res_status, res_latency, res_value}, sb_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic stim(input logic e);
    stim_valid  = 1'b1;
    expect_data = e;
    tick();
    stim_valid  = 1'b0;
  endtask

  // seq[i] is the obs_data sampled at latency i+1
  task automatic drive_obs(input logic [63:0] seq, input int unsigned n);
    for (int unsigned i = 0; i < n; i++) begin
      obs_data = seq[i];
      tick();
    end
  endtask

  task automatic fill_fifo();
    for (int unsigned k = 1; k <= DEPTH; k++) begin
      obs_data = 1'b0;
      stim(1'b1);
      sb_q.push_back(ent(2'b00, k, 1'b1));
      drive_obs(64'b11 << (k - 1), k + 1);
    end
  endtask

  task automatic drain(input int unsigned cycles);
    res_ready = 1'b1;
    for (int unsigned i = 0; i < cycles; i++) tick();
    check("sb_empty", sb_q.size(), 0);
    check("drain_valid", res_valid, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rst_n       = 1'b0;
    stim_valid  = 1'b0;
    expect_data = '0;
    obs_data    = '0;
    clear       = 1'b0;
    res_ready   = 1'b1;
    #2;
    check("rst_out", {res_valid, busy, overflow, res_status, res_latency, res_value}, 0);
    #20;
    rst_n = 1'b1;
    tick();

    // Settle at latency 3, visible right after the recording edge
    stim(1'b1);
    check("busy_wait", busy, 1);
    sb_q.push_back(ent(2'b00, 3, 1'b1));
    drive_obs(64'b1100, 4);
    check("settle_valid", res_valid, 1);
    check("settle_idle", busy, 0);
    tick();

    // Expect 0, minimum latency of 1
    obs_data = 1'b1;
    stim(1'b0);
    sb_q.push_back(ent(2'b00, 1, 1'b0));
    drive_obs(64'b00, 2);
    tick();

    // Glitch at L=2 must not produce an entry
    obs_data = 1'b0;
    stim(1'b1);
    sb_q.push_back(ent(2'b00, 5, 1'b1));
    drive_obs(64'b110010, 6);
    tick();

    // Timeout
    obs_data = 1'b0;
    stim(1'b1);
    sb_q.push_back(ent(2'b01, TMO, 1'b0));
    drive_obs(64'b0, TMO - 1);
    check("tmo_busy_before", busy, 1);
    drive_obs(64'b0, 1);
    check("tmo_busy_after", busy, 0);
    drive_obs(64'b0, 5);

    // Abort by second stimulus at L=4, then settle at L=2
    stim(1'b1);
    drive_obs(64'b0, 3);
    sb_q.push_back(ent(2'b10, 4, 1'b0));
    stim(1'b1);
    sb_q.push_back(ent(2'b00, 2, 1'b1));
    drive_obs(64'b110, 3);
    tick();
    tick();
    check("sb_empty_mid", sb_q.size(), 0);

    // Overflow: nine results with the consumer stalled
    res_ready = 1'b0;
    fill_fifo();
    check("full_no_ovf", overflow, 0);
    check("head_hold", res_latency, 1);
    obs_data = 1'b0;
    stim(1'b1);
    drive_obs(64'b11 << 8, 10);
    check("ovf_set", overflow, 1);
    drain(12);
    check("ovf_sticky", overflow, 1);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check("clear_ovf", overflow, 0);

    // Reset in the middle of a measurement
    obs_data = 1'b0;
    stim(1'b1);
    drive_obs(64'b0, 3);
    rst_n = 1'b0;
    #2;
    check("mid_rst_out", {res_valid, busy, overflow, res_status, res_latency, res_value}, 0);
    rst_n = 1'b1;
    tick();
    drive_obs(64'b1111, 4);
    check("post_rst_busy", busy, 0);
    check("post_rst_valid", res_valid, 0);

    // Full FIFO with push and pop on the same edge
    res_ready = 1'b0;
    obs_data  = 1'b0;
    fill_fifo();
    stim(1'b1);
    sb_q.push_back(ent(2'b00, 1, 1'b1));
    obs_data = 1'b1;
    tick();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("pp_no_ovf", overflow, 0);
    check("pp_valid", res_valid, 1);
    drain(12);
    check("pp_ovf_end", overflow, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
